mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 256 KB main memory (synchronous RAM, one-cycle read latency) between the core88 bus and a DMA requester such as an SD-to-RAM block-transfer engine. It sits between the requesters and the memory instance, replacing the direct core-to-memory connection inside the existing address-routing decode. It serialises accesses with round-robin priority and returns read data and an acknowledge pulse to the requester that was served.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_rr_pick2.sv | 25 ++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the two-port main-memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_CAPTURE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a tie goes to the port not served last.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic   i_elig_cpu,
    input  logic   i_elig_dma,
    input  owner_t i_last_grant,
    output logic   o_grant_valid,
    output owner_t o_grant_owner
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_grant_valid = i_elig_cpu | i_elig_dma;
        o_grant_owner = OWN_CPU;
        if (i_elig_cpu && i_elig_dma) begin
            if (i_last_grant == OWN_CPU) begin
                o_grant_owner = OWN_DMA;
            end
        end else if (i_elig_dma) begin
            o_grant_owner = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises core88 and DMA accesses onto one single-port synchronous RAM;
// each access takes IDLE(grant) -> ISSUE -> CAPTURE, with the ack in the following IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    owner_t            r_owner;
    owner_t            r_last_grant;
    logic              r_is_write;
    logic              r_cpu_ack;
    logic              r_dma_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;

    logic   w_elig_cpu;
    logic   w_elig_dma;
    logic   w_pick_valid;
    owner_t w_pick_owner;
    logic   w_grant;
    logic   w_issue;
    logic   w_capture;

    // A requester in its ack cycle is about to drop req, so it must not be re-granted.
    assign w_elig_cpu = cpu_req & ~r_cpu_ack;
    assign w_elig_dma = dma_req & ~r_dma_ack;

    rr_pick2 u_pick (
        .i_elig_cpu    (w_elig_cpu),
        .i_elig_dma    (w_elig_dma),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_pick_valid),
        .o_grant_owner (w_pick_owner)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = ARB_CAPTURE;
            end
            ARB_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_DMA;
            r_is_write   <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;

            if (w_grant) begin
                r_owner      <= w_pick_owner;
                r_last_grant <= w_pick_owner;
                if (w_pick_owner == OWN_DMA) begin
                    r_mem_addr  <= dma_addr;
                    r_mem_wdata <= dma_wdata;
                    r_mem_we    <= dma_we;
                    r_is_write  <= dma_we;
                end else begin
                    r_mem_addr  <= cpu_addr;
                    r_mem_wdata <= cpu_wdata;
                    r_mem_we    <= cpu_we;
                    r_is_write  <= cpu_we;
                end
            end

            // The RAM samples the write at the end of ISSUE; hold it for exactly that cycle.
            if (w_issue || w_capture) begin
                r_mem_we <= 1'b0;
            end

            if (w_capture) begin
                if (r_owner == OWN_DMA) begin
                    r_dma_ack <= 1'b1;
                    if (!r_is_write) begin
                        r_dma_rdata <= mem_q;
                    end
                end else begin
                    r_cpu_ack <= 1'b1;
                    if (!r_is_write) begin
                        r_cpu_rdata <= mem_q;
                    end
                end
            end
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign dma_ack   = r_dma_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed timing cases plus a randomized
// two-requester soak scored against an array model of main memory.
module tb_mem_arbiter;

    localparam int AW    = 18;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int SOAK  = 2000;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_ack;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    bit   [DW-1:0] ram       [DEPTH];
    bit   [DW-1:0] model_mem [DEPTH];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cycles = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
    );

    initial forever #5 clock = ~clock;

    // Synchronous single-port RAM with one-cycle read latency, plus a preload port.
    always @(posedge clock) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (mem_we) we_cycles++;
    endtask

    task automatic drive(input int p, input bit req, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end else begin
            dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
        model_mem[a] = d;
    endtask

    // Single access with the other port idle; req is dropped the cycle after ack.
    task automatic access(input int p, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
        int t0;
        drive(p, 1'b1, we, a, d);
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < 12 && lat < 0; i++) begin
            step();
            if ((p == 0) ? cpu_ack : dma_ack) lat = cyc - t0;
        end
        rd = (p == 0) ? cpu_rdata : dma_rdata;
        step();
        drive(p, 1'b0, 1'b0, a, d);
        if (we) model_mem[a] = d;
    endtask

    logic [AW-1:0] pool [8];
    bit            act  [2];
    int            rise [2];
    int            gap  [2];
    bit            s_we [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_wd   [2];
    logic [DW-1:0] last_rd [2];
    logic          ack  [2];
    logic [DW-1:0] rd   [2];

    initial begin
        logic [DW-1:0] rdv;
        int lat, t0, we0, k, issued, done;

        reset = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_cpu_ack",   32'(cpu_ack),   0);
        check("rst_dma_ack",   32'(dma_ack),   0);
        check("rst_mem_we",    32'(mem_we),    0);
        check("rst_mem_addr",  32'(mem_addr),  0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_dma_rdata", 32'(dma_rdata), 0);
        reset = 1'b0;

        // CPU read alone, then ack/req overlap with the address changed after ack.
        preload(18'h01234, 8'h5A);
        drive(0, 1'b1, 1'b0, 18'h01234, 8'h00);
        step();
        check("t1_c1_mem_addr", 32'(mem_addr), 32'h01234);
        check("t1_c1_mem_we",   32'(mem_we),   0);
        check("t1_c1_cpu_ack",  32'(cpu_ack),  0);
        step();
        check("t1_c2_cpu_ack",  32'(cpu_ack),  0);
        step();
        check("t1_c3_cpu_ack",   32'(cpu_ack),   1);
        check("t1_c3_cpu_rdata", 32'(cpu_rdata), 32'h5A);
        check("t1_c3_dma_ack",   32'(dma_ack),   0);
        cpu_addr = 18'h2AAAA;
        step();
        cpu_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ovl_cpu_ack",  32'(cpu_ack),  0);
            check("ovl_mem_addr", 32'(mem_addr), 32'h01234);
            check("ovl_dma_ack",  32'(dma_ack),  0);
            step();
        end

        // DMA write then CPU read of the same address.
        we0 = we_cycles;
        access(1, 1'b1, 18'h00100, 8'hC3, rdv, lat);
        check("t2_dma_wr_lat",   32'(lat),       3);
        check("t2_dma_rdata",    32'(dma_rdata), 0);
        check("t2_cpu_rdata",    32'(cpu_rdata), 32'h5A);
        access(0, 1'b0, 18'h00100, 8'h00, rdv, lat);
        check("t2_cpu_rd_lat",   32'(lat),       3);
        check("t2_cpu_rd_data",  32'(rdv),       32'hC3);
        check("t2_we_cycles",    32'(we_cycles - we0), 1);

        // Tie after reset: strict alternation starting with the CPU.
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 18'h01234, 8'h00);
        drive(1, 1'b1, 1'b0, 18'h00100, 8'h00);
        t0 = cyc;
        for (int i = 1; i <= 13; i++) begin
            step();
            k = cyc - t0;
            check("tie_cpu_ack", 32'(cpu_ack), 32'((k % 6) == 3));
            check("tie_dma_ack", 32'(dma_ack), 32'((k % 6) == 0));
            if (cpu_ack) check("tie_cpu_rdata", 32'(cpu_rdata), 32'h5A);
            if (dma_ack) check("tie_dma_rdata", 32'(dma_rdata), 32'hC3);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (4) step();

        // Reset during ISSUE of a DMA write to the top address.
        drive(1, 1'b1, 1'b1, 18'h3FFFF, 8'h55);
        step();
        check("rsti_mem_we",    32'(mem_we),    1);
        check("rsti_mem_addr",  32'(mem_addr),  32'h3FFFF);
        check("rsti_mem_wdata", 32'(mem_wdata), 32'h55);
        #2 reset = 1'b1;
        #1;
        check("rsti_we_drop",    32'(mem_we),    0);
        check("rsti_cpu_rdata",  32'(cpu_rdata), 0);
        check("rsti_dma_rdata",  32'(dma_rdata), 0);
        dma_req = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rsti_no_dma_ack", 32'(dma_ack), 0);
            check("rsti_no_cpu_ack", 32'(cpu_ack), 0);
        end
        drive(0, 1'b1, 1'b0, 18'h3FFFF, 8'h00);
        drive(1, 1'b1, 1'b0, 18'h00100, 8'h00);
        t0 = cyc;
        repeat (3) step();
        check("rsti_tie_cpu_ack",   32'(cpu_ack),   1);
        check("rsti_tie_dma_ack",   32'(dma_ack),   0);
        check("rsti_aborted_write", 32'(cpu_rdata), 32'(model_mem[18'h3FFFF]));
        cpu_req = 1'b0;
        repeat (3) step();
        check("rsti_dma_ack_c6",   32'(dma_ack),   1);
        check("rsti_dma_rdata_c6", 32'(dma_rdata), 32'hC3);
        dma_req = 1'b0;
        repeat (4) step();

        // Randomized soak against the memory model.
        pool[0] = 18'h01234; pool[1] = 18'h00100; pool[2] = 18'h3FFFF; pool[3] = 18'h00000;
        pool[4] = 18'h2AAAA; pool[5] = 18'h15555; pool[6] = 18'h00007; pool[7] = 18'h3FF00;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'hC3;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; gap[p] = 0; rise[p] = 0;
            s_we[p] = 1'b0; s_addr[p] = '0; s_wd[p] = '0;
        end
        issued = 0;
        done   = 0;
        for (int it = 0; it < 40000 && done < SOAK; it++) begin
            step();
            ack[0] = cpu_ack;   ack[1] = dma_ack;
            rd[0]  = cpu_rdata; rd[1]  = dma_rdata;
            for (int p = 0; p < 2; p++) begin
                bit fresh;
                fresh = 1'b0;
                if (ack[p]) begin
                    check("soak_ack_expected", 32'(act[p]), 1);
                    if (act[p]) begin
                        lat = cyc - rise[p];
                        check("soak_latency_3to6", 32'(lat >= 3 && lat <= 6), 1);
                        if (s_we[p]) model_mem[s_addr[p]] = s_wd[p];
                        else last_rd[p] = model_mem[s_addr[p]];
                        act[p] = 1'b0;
                        done++;
                        gap[p] = int'($urandom_range(0, 3));
                        fresh  = 1'b1;
                    end
                end else if (act[p] && (cyc - rise[p] > 6)) begin
                    check("soak_wait_bound", 32'(cyc - rise[p]), 6);
                    rise[p] = cyc;
                end
                check("soak_rdata", 32'(rd[p]), 32'(last_rd[p]));
                if (!act[p]) begin
                    if (gap[p] == 0 && issued < SOAK) begin
                        act[p]    = 1'b1;
                        // A request raised in its own ack cycle is first eligible next cycle.
                        rise[p]   = fresh ? cyc + 1 : cyc;
                        s_we[p]   = 1'($urandom_range(0, 1));
                        s_addr[p] = pool[$urandom_range(0, 7)];
                        s_wd[p]   = 8'($urandom);
                        issued++;
                    end else if (gap[p] > 0) begin
                        gap[p]--;
                    end
                end
                if (act[p]) drive(p, 1'b1, s_we[p], s_addr[p], s_wd[p]);
                else        drive(p, 1'b0, 1'($urandom), 18'($urandom), 8'($urandom));
            end
        end
        check("soak_completed", 32'(done), SOAK);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
